// File: rtl/tnoc_vc_input_buffer.sv
// Multi-VC flit input buffer: one circular FIFO per virtual channel, shared write port, per-VC read ports.
// Optional per-VC credit-return pulses are compiled in with `define TNOC_VC_INPUT_BUFFER_CREDIT_EN.
module tnoc_vc_input_buffer #(
    parameter  int CHANNELS   = 2,
    parameter  int DATA_WIDTH = 64,
    parameter  int DEPTH      = 8,
    parameter  int THRESHOLD  = DEPTH - 2,
    localparam int VW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_clear,
    input  logic                           i_flit_valid,
    input  logic [VW-1:0]                  i_flit_vc,
    input  logic [DATA_WIDTH-1:0]          i_flit_data,
    output logic [CHANNELS-1:0]            o_flit_ready,
    output logic [CHANNELS-1:0]            o_flit_valid,
    input  logic [CHANNELS-1:0]            i_flit_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] o_flit_data,
    output logic [CHANNELS-1:0]            o_empty,
    output logic [CHANNELS-1:0]            o_almost_full,
    output logic [CHANNELS-1:0]            o_full,
    output logic [CHANNELS*CW-1:0]         o_count,
`ifdef TNOC_VC_INPUT_BUFFER_CREDIT_EN
    output logic [CHANNELS-1:0]            o_credit_return,
`endif
    output logic                           o_error
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [CHANNELS][DEPTH];
    logic [PW-1:0]         wr_ptr_q [CHANNELS];
    logic [PW-1:0]         wr_ptr_d [CHANNELS];
    logic [PW-1:0]         rd_ptr_q [CHANNELS];
    logic [PW-1:0]         rd_ptr_d [CHANNELS];
    logic [CW-1:0]         count_q  [CHANNELS];
    logic [CW-1:0]         count_d  [CHANNELS];
    logic                  error_q;
    logic                  error_d;

    logic [CHANNELS-1:0]   vc_hit;
    logic [CHANNELS-1:0]   full;
    logic [CHANNELS-1:0]   empty;
    logic [CHANNELS-1:0]   push;
    logic [CHANNELS-1:0]   pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Decoding the VC per channel makes an out-of-range index simply hit nothing.
    always_comb begin
        vc_hit = '0;
        full   = '0;
        empty  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            vc_hit[i] = (i_flit_vc == VW'(i));
            full[i]   = (count_q[i] == CW'(DEPTH));
            empty[i]  = (count_q[i] == '0);
        end
    end

    assign push    = {CHANNELS{i_flit_valid}} & vc_hit & ~full;
    assign pop     = i_flit_ready & ~empty;
    assign error_d = error_q | (i_flit_valid & ~(|push));

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            count_d[i]  = count_q[i];
            if (i_clear) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end else begin
                if (push[i]) wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
                if (pop[i])  rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
                case ({push[i], pop[i]})
                    2'b10:   count_d[i] = count_q[i] + 1'b1;
                    2'b01:   count_d[i] = count_q[i] - 1'b1;
                    default: count_d[i] = count_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            error_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            error_q <= error_d;
        end
    end

    // NOTE: storage has no reset; entries are only observable once count says they were written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= i_flit_data;
        end
    end

    always_comb begin
        o_flit_data   = '0;
        o_count       = '0;
        o_almost_full = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            o_flit_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rd_ptr_q[i]];
            o_count[i*CW +: CW]                     = count_q[i];
            o_almost_full[i]                        = (count_q[i] >= CW'(THRESHOLD));
        end
    end

    assign o_flit_valid = ~empty;
    assign o_flit_ready = ~full;
    assign o_empty      = empty;
    assign o_full       = full;
    assign o_error      = error_q;

`ifdef TNOC_VC_INPUT_BUFFER_CREDIT_EN
    logic [CHANNELS-1:0] credit_q;

    // A pop in a reset or clear cycle returns no credit: the flush already restores them all.
    always_ff @(posedge clk) begin
        if (rst || i_clear) credit_q <= '0;
        else                credit_q <= pop;
    end

    assign o_credit_return = credit_q;
`endif

endmodule

// File: tb/tb_tnoc_vc_input_buffer.sv
// Scoreboard bench for tnoc_vc_input_buffer: a 2-VC/depth-4 instance and a 3-VC/depth-3 instance.
// Credit-return checks are active when TNOC_VC_INPUT_BUFFER_CREDIT_EN is defined.
module tb_tnoc_vc_input_buffer;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: CHANNELS=2, DEPTH=4, THRESHOLD=2
    logic          a_rst, a_clear, a_valid;
    logic          a_vc;
    logic [DW-1:0] a_data;
    logic [1:0]    a_ready, a_oready, a_ovalid, a_empty, a_afull, a_full;
    logic [2*DW-1:0] a_odata;
    logic [5:0]    a_count;
    logic          a_error;
`ifdef TNOC_VC_INPUT_BUFFER_CREDIT_EN
    logic [1:0]    a_credit;
`endif

    tnoc_vc_input_buffer #(.CHANNELS(2), .DATA_WIDTH(DW), .DEPTH(4)) u_a (
        .clk(clk), .rst(a_rst), .i_clear(a_clear),
        .i_flit_valid(a_valid), .i_flit_vc(a_vc), .i_flit_data(a_data),
        .o_flit_ready(a_oready), .o_flit_valid(a_ovalid), .i_flit_ready(a_ready),
        .o_flit_data(a_odata), .o_empty(a_empty), .o_almost_full(a_afull),
        .o_full(a_full), .o_count(a_count),
`ifdef TNOC_VC_INPUT_BUFFER_CREDIT_EN
        .o_credit_return(a_credit),
`endif
        .o_error(a_error)
    );

    // ---------------- instance B: CHANNELS=3, DEPTH=3, THRESHOLD=1
    logic          b_rst, b_clear, b_valid;
    logic [1:0]    b_vc;
    logic [DW-1:0] b_data;
    logic [2:0]    b_ready, b_oready, b_ovalid, b_empty, b_afull, b_full;
    logic [3*DW-1:0] b_odata;
    logic [5:0]    b_count;
    logic          b_error;
`ifdef TNOC_VC_INPUT_BUFFER_CREDIT_EN
    logic [2:0]    b_credit;
`endif

    tnoc_vc_input_buffer #(.CHANNELS(3), .DATA_WIDTH(DW), .DEPTH(3)) u_b (
        .clk(clk), .rst(b_rst), .i_clear(b_clear),
        .i_flit_valid(b_valid), .i_flit_vc(b_vc), .i_flit_data(b_data),
        .o_flit_ready(b_oready), .o_flit_valid(b_ovalid), .i_flit_ready(b_ready),
        .o_flit_data(b_odata), .o_empty(b_empty), .o_almost_full(b_afull),
        .o_full(b_full), .o_count(b_count),
`ifdef TNOC_VC_INPUT_BUFFER_CREDIT_EN
        .o_credit_return(b_credit),
`endif
        .o_error(b_error)
    );

    // ---------------- reference model / scoreboard
    typedef struct {
        int            vc;
        logic [DW-1:0] data;
    } sb_t;

    sb_t           sb_a[$];
    int            a_cnt[2];
    bit            a_err;
    logic [1:0]    a_exp_cr;

    logic [DW-1:0] sb_b[$];
    int            b_cnt[3];
    bit            b_err;
    logic [2:0]    b_exp_cr;

    function automatic logic [DW-1:0] sb_a_pop(input int vc);
        logic [DW-1:0] r;
        r = 'x;
        for (int k = 0; k < sb_a.size(); k++) begin
            if (sb_a[k].vc == vc) begin
                r = sb_a[k].data;
                sb_a.delete(k);
                break;
            end
        end
        return r;
    endfunction

    task automatic a_check();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("a_count[%0d]", i), a_count[i*3 +: 3], a_cnt[i]);
            check($sformatf("a_empty[%0d]", i), a_empty[i], a_cnt[i] == 0);
            check($sformatf("a_valid[%0d]", i), a_ovalid[i], a_cnt[i] != 0);
            check($sformatf("a_full[%0d]", i), a_full[i], a_cnt[i] == 4);
            check($sformatf("a_ready[%0d]", i), a_oready[i], a_cnt[i] != 4);
            check($sformatf("a_afull[%0d]", i), a_afull[i], a_cnt[i] >= 2);
        end
        check("a_error", a_error, a_err);
`ifdef TNOC_VC_INPUT_BUFFER_CREDIT_EN
        check("a_credit", a_credit, a_exp_cr);
`endif
    endtask

    task automatic a_step(input bit v, input int vc, input logic [DW-1:0] d,
                          input logic [1:0] rdy, input bit clr);
        logic [1:0] pop;
        bit         ok;
        a_valid = v; a_vc = 1'(vc); a_data = d; a_ready = rdy; a_clear = clr;
        for (int i = 0; i < 2; i++) begin
            pop[i] = rdy[i] && (a_cnt[i] > 0);
            if (pop[i]) check($sformatf("a_head[%0d]", i), a_odata[i*DW +: DW], sb_a_pop(i));
        end
        ok = v && (a_cnt[vc] < 4);
        @(posedge clk); #1;
        if (v && !ok) a_err = 1'b1;
        if (clr) begin
            sb_a.delete();
            a_cnt    = '{0, 0};
            a_exp_cr = '0;
        end else begin
            for (int i = 0; i < 2; i++) if (pop[i]) a_cnt[i]--;
            if (ok) begin
                sb_a.push_back('{vc, d});
                a_cnt[vc]++;
            end
            a_exp_cr = pop;
        end
        a_valid = 1'b0; a_ready = '0; a_clear = 1'b0;
        a_check();
    endtask

    // Reset is applied with a push and pops in flight; rst must discard them.
    task automatic a_reset();
        a_rst = 1'b1; a_valid = 1'b1; a_vc = 1'b0; a_data = 16'hDEAD; a_ready = 2'b11;
        @(posedge clk); #1;
        a_rst = 1'b0; a_valid = 1'b0; a_ready = '0;
        sb_a.delete();
        a_cnt = '{0, 0}; a_err = 1'b0; a_exp_cr = '0;
        a_check();
    endtask

    task automatic b_check();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b_count[%0d]", i), b_count[i*2 +: 2], b_cnt[i]);
            check($sformatf("b_empty[%0d]", i), b_empty[i], b_cnt[i] == 0);
            check($sformatf("b_full[%0d]", i), b_full[i], b_cnt[i] == 3);
        end
        check("b_error", b_error, b_err);
`ifdef TNOC_VC_INPUT_BUFFER_CREDIT_EN
        check("b_credit", b_credit, b_exp_cr);
`endif
    endtask

    // Only VC0 carries data in this instance; other indices exercise the drop path.
    task automatic b_step(input bit v, input int vc, input logic [DW-1:0] d,
                          input bit rdy0, input bit clr);
        bit pop0;
        bit ok;
        b_valid = v; b_vc = 2'(vc); b_data = d; b_ready = {2'b00, rdy0}; b_clear = clr;
        pop0 = rdy0 && (b_cnt[0] > 0);
        if (pop0) check("b_head[0]", b_odata[DW-1:0], sb_b.pop_front());
        ok = v && (vc < 3) && (b_cnt[vc < 3 ? vc : 0] < 3);
        @(posedge clk); #1;
        if (v && !ok) b_err = 1'b1;
        if (clr) begin
            sb_b.delete();
            b_cnt    = '{0, 0, 0};
            b_exp_cr = '0;
        end else begin
            if (pop0) b_cnt[0]--;
            if (ok) begin
                if (vc == 0) sb_b.push_back(d);
                b_cnt[vc]++;
            end
            b_exp_cr = {2'b00, pop0};
        end
        b_valid = 1'b0; b_ready = '0; b_clear = 1'b0;
        b_check();
    endtask

    task automatic b_reset();
        b_rst = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0;
        sb_b.delete();
        b_cnt = '{0, 0, 0}; b_err = 1'b0; b_exp_cr = '0;
        b_check();
    endtask

    initial begin
        a_rst = 1'b0; a_clear = 1'b0; a_valid = 1'b0; a_vc = 1'b0; a_data = '0; a_ready = '0;
        b_rst = 1'b0; b_clear = 1'b0; b_valid = 1'b0; b_vc = '0;   b_data = '0; b_ready = '0;
        #1;

        // A: reset state, then two flits on VC0 visible one cycle after the push
        a_reset();
        a_step(1'b1, 0, 16'h00A0, 2'b00, 1'b0);
        check("a_head_after_A", a_odata[DW-1:0], 16'h00A0);
        a_step(1'b1, 0, 16'h00B0, 2'b00, 1'b0);

        // A: fill VC1 through almost-full to full, fifth push dropped
        for (int k = 0; k < 5; k++) a_step(1'b1, 1, 16'h0100 + 16'(k), 2'b00, 1'b0);

        // A: independent pops on both VCs, then VC1 alone
        a_step(1'b0, 0, '0, 2'b11, 1'b0);
        a_step(1'b0, 0, '0, 2'b10, 1'b0);
        a_step(1'b0, 0, '0, 2'b10, 1'b0);

        // A: push+pop on a non-full VC keeps the count; on a full VC the push is refused
        a_step(1'b1, 1, 16'h0200, 2'b10, 1'b0);
        for (int k = 0; k < 3; k++) a_step(1'b1, 1, 16'h0210 + 16'(k), 2'b00, 1'b0);
        a_step(1'b1, 1, 16'h0300, 2'b10, 1'b0);

        // A: clear with push+pop on VC0 at count 2; error survives clear
        a_step(1'b1, 0, 16'h0400, 2'b00, 1'b0);
        a_step(1'b1, 0, 16'h0410, 2'b01, 1'b1);
        check("a_error_after_clear", a_error, 1'b1);

        // A: random traffic with occasional clears
        a_reset();
        repeat (120) begin
            a_step(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), DW'($urandom),
                   2'($urandom_range(0, 3)), ($urandom_range(0, 24) == 0));
        end

        // B: depth-3 wrap under steady push+pop on VC0
        b_reset();
        b_step(1'b1, 0, 16'h5000, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) b_step(1'b1, 0, 16'h6000 + 16'(k), 1'b1, 1'b0);
        b_step(1'b0, 0, '0, 1'b1, 1'b0);

        // B: out-of-range VC dropped, counts unchanged, error sticky through clear
        b_step(1'b1, 0, 16'h7700, 1'b0, 1'b0);
        b_step(1'b1, 3, 16'h0BAD, 1'b0, 1'b0);
        b_step(1'b0, 0, '0, 1'b1, 1'b1);
        check("b_error_after_clear", b_error, 1'b1);
        b_reset();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
